// File: rtl/psg_pkg.sv
// Shared constants for the multi-channel PSG: level table, register map,
// envelope shape bit positions and the noise LFSR seed.
package psg_pkg;

  // Log-scaled output level, index 0 silent, index 31 full scale.
  localparam logic [7:0] VOL_TABLE [32] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
    8'h08, 8'h0A, 8'h0C, 8'h0E, 8'h10, 8'h13, 8'h16, 8'h1A,
    8'h1F, 8'h25, 8'h2B, 8'h33, 8'h3C, 8'h47, 8'h54, 8'h63,
    8'h75, 8'h8A, 8'hA3, 8'hC0, 8'hD2, 8'hE2, 8'hF0, 8'hFF
  };

  localparam logic [2:0] OFS_TONE_LO = 3'd0;
  localparam logic [2:0] OFS_TONE_HI = 3'd1;
  localparam logic [2:0] OFS_VOL     = 3'd2;
  localparam logic [2:0] OFS_ENV_LO  = 3'd3;
  localparam logic [2:0] OFS_ENV_HI  = 3'd4;
  localparam logic [2:0] OFS_SHAPE   = 3'd5;
  localparam logic [2:0] OFS_MIXER   = 3'd6;
  localparam logic [7:0] ADDR_NOISE  = 8'hF8;

  localparam int SH_HOLD = 0;
  localparam int SH_ALT  = 1;
  localparam int SH_ATT  = 2;
  localparam int SH_CONT = 3;

  localparam logic [16:0] LFSR_SEED = 17'h1;

endpackage

// File: rtl/psg_env_gen.sv
// One envelope generator: 16-bit step counter, 5-bit volume and a run/hold
// state machine driven by the CONT/ATT/ALT/HOLD shape bits.
module psg_env_gen
  import psg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ena,
  input  logic        restart,
  input  logic [3:0]  shape,
  input  logic [15:0] period,
  output logic [4:0]  vol
);

  localparam logic [0:0] ENV_RUN  = 1'b0;
  localparam logic [0:0] ENV_HOLD = 1'b1;

  logic [0:0]  state;
  logic [15:0] cnt;
  logic [15:0] last;
  logic        dir_up;
  logic        step;
  logic        at_end;

  assign last   = (period == 16'd0) ? 16'd0 : period - 16'd1;
  assign step   = ena && (cnt >= last);
  assign at_end = dir_up ? (vol == 5'd31) : (vol == 5'd0);

  // A restart in the same cycle as a step wins; the step is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      vol    <= '0;
      dir_up <= 1'b0;
      state  <= ENV_HOLD;
    end else if (restart) begin
      cnt    <= '0;
      state  <= ENV_RUN;
      dir_up <= shape[SH_ATT];
      vol    <= shape[SH_ATT] ? 5'd0 : 5'd31;
    end else begin
      if (ena) cnt <= step ? 16'd0 : cnt + 16'd1;
      if (step && state == ENV_RUN) begin
        if (!at_end) begin
          vol <= dir_up ? vol + 5'd1 : vol - 5'd1;
        end else if (!shape[SH_CONT]) begin
          vol   <= 5'd0;
          state <= ENV_HOLD;
        end else if (shape[SH_HOLD]) begin
          vol   <= shape[SH_ALT] ? ~vol : vol;
          state <= ENV_HOLD;
        end else if (shape[SH_ALT]) begin
          // Reverse without repeating the endpoint.
          dir_up <= !dir_up;
          vol    <= dir_up ? 5'd30 : 5'd1;
        end else begin
          vol <= dir_up ? 5'd0 : 5'd31;
        end
      end
    end
  end

endmodule

// File: rtl/psg_multi.sv
// Multi-channel PSG: tone channels, shared 17-bit noise, per-channel envelopes
// and a registered mix. Define PSG_STEREO_PAN_EN for per-channel pan and MIX_R.
module psg_multi
  import psg_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int TONE_W   = 12,
  parameter int DIV      = 8,
  parameter int MIX_W    = 8 + $clog2(CHANNELS + 1)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CE,
  input  logic                  WR,
  input  logic [7:0]            ADDR,
  input  logic [7:0]            WDATA,
  output logic [7:0]            RDATA,
  output logic [CHANNELS*8-1:0] CH_OUT,
  output logic [MIX_W-1:0]      MIX
`ifdef PSG_STEREO_PAN_EN
  ,
  output logic [MIX_W-1:0]      MIX_R
`endif
);

  localparam int PRE_W = $clog2(DIV);
`ifdef PSG_STEREO_PAN_EN
  localparam int MIXER_W = 4;
`else
  localparam int MIXER_W = 2;
`endif

  logic [PRE_W-1:0]   pre_cnt;
  logic               ena;
  logic               noise_phase;
  logic               noise_tick;
  logic [4:0]         noise_per;
  logic [4:0]         noise_cnt;
  logic [4:0]         noise_last;
  logic [16:0]        lfsr;
  logic [4:0]         ch_sel;
  logic [2:0]         ofs;

  logic [TONE_W-1:0]  tone_per  [CHANNELS];
  logic [TONE_W-1:0]  tone_cnt  [CHANNELS];
  logic [CHANNELS-1:0] tone;
  logic [4:0]         vol_reg   [CHANNELS];
  logic [15:0]        env_per   [CHANNELS];
  logic [3:0]         shape_reg [CHANNELS];
  logic [MIXER_W-1:0] mixer     [CHANNELS];
  logic [CHANNELS-1:0] env_restart;
  logic [3:0]         env_shape [CHANNELS];
  logic [4:0]         env_vol   [CHANNELS];
  logic [CHANNELS-1:0] gate;
  logic [4:0]         level_idx [CHANNELS];
  logic [MIX_W-1:0]   sum_l;
`ifdef PSG_STEREO_PAN_EN
  logic [MIX_W-1:0]   sum_r;
`endif

  assign ch_sel = ADDR[7:3];
  assign ofs    = ADDR[2:0];

  assign ena        = CE && (pre_cnt == PRE_W'(DIV - 1));
  assign noise_tick = ena && noise_phase;
  assign noise_last = (noise_per == 5'd0) ? 5'd0 : noise_per - 5'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pre_cnt <= '0;
    end else if (CE) begin
      pre_cnt <= ena ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      noise_phase <= 1'b0;
      noise_cnt   <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      if (ena) noise_phase <= !noise_phase;
      if (noise_tick) begin
        if (noise_cnt >= noise_last) begin
          noise_cnt <= '0;
          lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
        end else begin
          noise_cnt <= noise_cnt + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      noise_per <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        tone_per[c]  <= '0;
        vol_reg[c]   <= '0;
        env_per[c]   <= '0;
        shape_reg[c] <= '0;
        mixer[c]     <= MIXER_W'(2'b11);
      end
    end else if (WR) begin
      if (ADDR == ADDR_NOISE) noise_per <= WDATA[4:0];
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(ch_sel) == c) begin
          case (ofs)
            OFS_TONE_LO: tone_per[c][7:0]        <= WDATA;
            OFS_TONE_HI: tone_per[c][TONE_W-1:8] <= WDATA[TONE_W-9:0];
            OFS_VOL:     vol_reg[c]              <= WDATA[4:0];
            OFS_ENV_LO:  env_per[c][7:0]         <= WDATA;
            OFS_ENV_HI:  env_per[c][15:8]        <= WDATA;
            OFS_SHAPE:   shape_reg[c]            <= WDATA[3:0];
            OFS_MIXER:   mixer[c]                <= WDATA[MIXER_W-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // The envelope restarts with the shape being written, not the old one.
  always_comb begin
    env_restart = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      env_restart[c] = WR && (int'(ch_sel) == c) && (ofs == OFS_SHAPE);
      env_shape[c]   = env_restart[c] ? WDATA[3:0] : shape_reg[c];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    psg_env_gen u_env (
      .clk     (CLK),
      .reset   (RESET),
      .ena     (ena),
      .restart (env_restart[g]),
      .shape   (env_shape[g]),
      .period  (env_per[g]),
      .vol     (env_vol[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tone <= '0;
      for (int c = 0; c < CHANNELS; c++) tone_cnt[c] <= '0;
    end else if (ena) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (tone_per[c] == '0) begin
          tone_cnt[c] <= '0;
          tone[c]     <= 1'b1;
        end else if (tone_cnt[c] >= tone_per[c] - TONE_W'(1)) begin
          tone_cnt[c] <= '0;
          tone[c]     <= !tone[c];
        end else begin
          tone_cnt[c] <= tone_cnt[c] + TONE_W'(1);
        end
      end
    end
  end

  always_comb begin
    gate = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      gate[c] = (tone[c] | mixer[c][0]) & (lfsr[0] | mixer[c][1]);
      if (!gate[c])          level_idx[c] = 5'd0;
      else if (vol_reg[c][4]) level_idx[c] = env_vol[c];
      else                    level_idx[c] = {vol_reg[c][3:0], vol_reg[c][3]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      CH_OUT <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) CH_OUT[c*8 +: 8] <= VOL_TABLE[level_idx[c]];
    end
  end

  // Pan 00 centre, 01 left, 10 right, 11 mute.
  always_comb begin
    sum_l = '0;
`ifdef PSG_STEREO_PAN_EN
    sum_r = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mixer[c][3:2] == 2'b00 || mixer[c][3:2] == 2'b01)
        sum_l = sum_l + MIX_W'(CH_OUT[c*8 +: 8]);
      if (mixer[c][3:2] == 2'b00 || mixer[c][3:2] == 2'b10)
        sum_r = sum_r + MIX_W'(CH_OUT[c*8 +: 8]);
    end
`else
    for (int c = 0; c < CHANNELS; c++) sum_l = sum_l + MIX_W'(CH_OUT[c*8 +: 8]);
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      MIX <= '0;
`ifdef PSG_STEREO_PAN_EN
      MIX_R <= '0;
`endif
    end else begin
      MIX <= sum_l;
`ifdef PSG_STEREO_PAN_EN
      MIX_R <= sum_r;
`endif
    end
  end

  always_comb begin
    RDATA = 8'hFF;
    if (ADDR == ADDR_NOISE) begin
      RDATA = {3'b000, noise_per};
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (int'(ch_sel) == c) begin
          case (ofs)
            OFS_TONE_LO: RDATA = tone_per[c][7:0];
            OFS_TONE_HI: RDATA = 8'(tone_per[c][TONE_W-1:8]);
            OFS_VOL:     RDATA = {3'b000, vol_reg[c]};
            OFS_ENV_LO:  RDATA = env_per[c][7:0];
            OFS_ENV_HI:  RDATA = env_per[c][15:8];
            OFS_SHAPE:   RDATA = {4'b0000, shape_reg[c]};
            OFS_MIXER:   RDATA = 8'(mixer[c]);
            default:     RDATA = 8'hFF;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/psg_multi.md
# psg_multi

Parametrised programmable sound generator: CHANNELS square-wave tone channels, one shared 17-bit noise LFSR, and one independent envelope generator per channel. Mixes channels to a summed audio word. It sits on the audio bus beside the legacy three-channel PSG and is driven by the CPU register bus with a CLK-domain clock enable.

## Interface
- CHANNELS, 3: number of tone channels, 1..30.
- TONE_W, 12: tone period width, 9..16.
- DIV, 8: CE ticks per generator step, at least 2.
- MIX_W, 8+$clog2(CHANNELS+1): width of the mix output.
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- CE  in  1  PSG clock enable.
- WR  in  1  register write strobe, one CLK.
- ADDR  in  8  register address.
- WDATA  in  8  write data.
- RDATA  out  8  read data for ADDR, combinational.
- CH_OUT  out  CHANNELS*8  per-channel log-scaled level; channel n is at [8n+7:8n].
- MIX  out  MIX_W  unsigned sum of all CH_OUT.
- MIX_R  out  MIX_W  right sum; present only with the pan feature (see Configuration).

## Operation
- Register map: per-channel base is ch*8.
  - +0: tone period lo.
  - +1: tone period hi, [TONE_W-9:0].
  - +2: volume; bit4 = envelope select, [3:0] = fixed level.
  - +3 / +4: envelope period lo / hi (16 bits).
  - +5: envelope shape [3:0] = CONT, ATT, ALT, HOLD. Any write restarts that channel's envelope.
  - +6: mixer; bit0 = tone disable, bit1 = noise disable, [3:2] = pan.
- Global: 0xF8 holds the noise period [4:0].
- Reads: unimplemented bits read 0; unmapped addresses read 0xFF.
- Prescaler: counts CE ticks and emits ena once every DIV ticks. Noise logic advances on every second ena.
- Tone:
  - The 12-bit-style up-counter (TONE_W wide) increments on ena.
  - When cnt >= period-1: cnt clears and tone toggles.
  - Period 0: tone is held at 1 and cnt is held at 0.
- Noise:
  - 5-bit counter with the same compare rule; period 0 behaves as period 1.
  - On wrap, the LFSR shifts right with feedback bit[0]^bit[3].
  - Noise output = LFSR bit[0].
- Gate: (tone | tone_disable) & (noise | noise_disable).
- Envelope (per channel):
  - 16-bit counter on ena; it steps when cnt >= period-1. Period 0 behaves as 1.
  - 5-bit volume. Restart sets vol=0 and direction up if ATT=1; otherwise vol=31 and direction down. Restart also clears hold.
  - At ramp end (a step from 31 up, or from 0 down):
    - CONT=0: hold at 0.
    - HOLD=1: hold at the end value, inverted if ALT=1.
    - ALT=1: reverse direction; no repeated endpoint.
    - Otherwise: wrap to the start value.
- Level selection:
  - Gate 0: level index is 0.
  - Gate 1 and envelope select set: index = env vol.
  - Gate 1 otherwise: index = {level, level[3]}.
  - CH_OUT = VOL_TABLE[index], 32 entries, 0x00..0xFF.

## Timing
- RESET (synchronous) clears all of the following:
  - all registers, except mixer bits [1:0] = 2'b11;
  - all counters, tone outputs and envelopes; envelopes go to vol=0 and held;
  - the LFSR, which is loaded with 17'h1;
  - CH_OUT, MIX and MIX_R, which read 0 one CLK later.
- Writes take effect at the CLK edge where WR=1. A new period is compared on the next ena. If cnt is already ≥ the new period-1, the channel wraps on that ena.
- Shape write in the same CLK as an envelope step: the restart wins and the step is discarded.
- CH_OUT is registered and follows a generator change by 1 CLK. MIX is registered 1 CLK after CH_OUT.
- Nothing advances when CE=0. RESET overrides CE.

## Configuration
- PSG_STEREO_PAN_EN defined:
  - Pan bits are implemented, with values 00 = centre, 01 = left, 10 = right, 11 = mute.
  - MIX carries the left sum: centre and left channels.
  - MIX_R carries the right sum: centre and right channels.
- PSG_STEREO_PAN_EN undefined:
  - Pan bits read 0.
  - MIX_R port is absent.
  - MIX sums all channels.

## Structure
- Package psg_pkg holds:
  - VOL_TABLE;
  - register offset localparams: OFS_TONE_LO..OFS_MIXER, ADDR_NOISE;
  - shape bit indices;
  - LFSR reset seed.
- Sub-module psg_env_gen holds the envelope counter, volume and shape FSM. It is instantiated CHANNELS times.

## Test plan
- Tone, ch0: period=4, DIV=8, mixer=0b10, level 15. Required: CH_OUT[7:0] toggles 0x00 / 0xFF every 32 CE ticks.
- Envelope, ch1: env period 1, shape 0b1110, env select. Required: vol runs 0→31→0 with no repeated 31 or 0; shape 0b1101 ends holding 31.
- Restart collision: shape write coincides with an envelope step. Required: vol equals the restart value on the next cycle.
- Noise: period 0 at 0xF8, tone disabled. Required: LFSR sequence from seed 1 matches the model; no lockup after 2^17-1 steps.
- Reset mid-operation: all channels active, RESET for 1 CLK. Required: CH_OUT=0 and MIX=0; register 6 of each channel reads 0x03; RDATA at 0xFF reads 0xFF.
- PSG_STEREO_PAN_EN: ch0 pan=01, ch1 pan=10, both at 0xFF. Required: MIX=0xFF and MIX_R=0xFF; pan=11 gives 0.
